// File: rtl/mac_feeder.sv
// mac_feeder: operand FIFO plus sequencer that streams operand pairs into an
// external MAC. When the pair marked "last" is issued, it captures the
// accumulated dot product, holds it on a valid/ready result port, and then
// clears the MAC for the next vector.
module mac_feeder #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_a,
  input  logic signed [15:0] in_b,
  input  logic               in_last,
  output logic               mac_en,
  output logic signed [15:0] mac_a,
  output logic signed [15:0] mac_b,
  output logic               mac_clr,
  input  logic signed [31:0] mac_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic signed [31:0] res_data,
  output logic [7:0]         res_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FILL_ONE  = (AW+1)'(1);
  localparam logic [AW:0] FILL_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_RESULT, S_CLEAR} state_t;

  // Each entry packs {a, b, last}.
  logic [32:0]        mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        fill_q, fill_d;
  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic signed [31:0] res_data_q, res_data_d;
  logic [7:0]         res_count_q, res_count_d;

  logic        full, empty, push, pop;
  logic [32:0] head;
  logic        head_last;

  assign full      = (fill_q == FILL_FULL);
  assign empty     = (fill_q == '0);
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign pop       = mac_en;
  assign head      = mem_q[rd_ptr_q];
  assign head_last = head[0];
  assign res_data  = res_data_q;
  assign res_count = res_count_q;

  // Operand storage: written at the tail; reads are asynchronous so the head
  // can be presented to the MAC in the same cycle it becomes available.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_a, in_b, in_last};
    end
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   fill_d = fill_q + FILL_ONE;
      2'b01:   fill_d = fill_q - FILL_ONE;
      default: fill_d = fill_q;
    endcase
  end

  // Next-state logic: a popped "last" pair ends the vector; WAIT gives the MAC
  // one edge to absorb the final product before it is sampled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:    if (pop && head_last) state_d = S_WAIT;
      S_WAIT:   state_d = S_RESULT;
      S_RESULT: if (res_ready) state_d = S_CLEAR;
      S_CLEAR:  state_d = S_RUN;
      default:  state_d = S_RUN;
    endcase
  end

  // Outputs decoded from the state; reset forces the MAC clear and blocks
  // issue and results even before the state register has been reset.
  always_comb begin
    mac_en    = !rst && (state_q == S_RUN) && !empty;
    mac_clr   = rst || (state_q == S_CLEAR);
    res_valid = !rst && (state_q == S_RESULT);
    mac_a     = mac_en ? $signed(head[32:17]) : 16'sd0;
    mac_b     = mac_en ? $signed(head[16:1])  : 16'sd0;
  end

  // Product count and result capture.
  always_comb begin
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_count_d = res_count_q;
    if (state_q == S_CLEAR) begin
      cnt_d = 8'd0;
    end else if (pop && (cnt_q != 8'd255)) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (state_q == S_WAIT) begin
      res_data_d  = mac_out;
      res_count_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      state_q     <= S_RUN;
      cnt_q       <= 8'd0;
      res_data_q  <= 32'sd0;
      res_count_q <= 8'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
    end
  end

endmodule
